// File: rtl/encrypter_dispatch_scheduler_if.sv
// Handshake/bus bundle between the dispatch scheduler and its surroundings:
// the Parallelizer input, the encrypter bank and the Collector.
interface encrypter_dispatch_scheduler_if #(
    parameter int unsigned NUM_ENC     = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ROT_W       = 5,
    parameter int unsigned ORDER_DEPTH = 8
);
    localparam int unsigned SEL_W = $clog2(NUM_ENC);
    localparam int unsigned CNT_W = $clog2(ORDER_DEPTH) + 1;

    logic                prog_start;
    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   enc_data;
    logic [ROT_W-1:0]    enc_key_rotation;
    logic [NUM_ENC-1:0]  enc_program;
    logic [NUM_ENC-1:0]  enc_data_ready;
    logic [NUM_ENC-1:0]  enc_ready;
    logic [NUM_ENC-1:0]  enc_done;
    logic [NUM_ENC-1:0]  enc_capture;
    logic                col_ready;
    logic                col_valid;
    logic [SEL_W-1:0]    col_sel;
    logic                key_loaded;
    logic [CNT_W-1:0]    inflight;

    // Scheduler side
    modport master (
        input  prog_start, in_data, in_valid, enc_ready, enc_done, col_ready,
        output in_ready, enc_data, enc_key_rotation, enc_program, enc_data_ready,
               enc_capture, col_valid, col_sel, key_loaded, inflight
    );

    // Environment side (Parallelizer, encrypters, Collector)
    modport slave (
        output prog_start, in_data, in_valid, enc_ready, enc_done, col_ready,
        input  in_ready, enc_data, enc_key_rotation, enc_program, enc_data_ready,
               enc_capture, col_valid, col_sel, key_loaded, inflight
    );
endinterface

// File: rtl/encrypter_dispatch_scheduler.sv
// Encrypter bank sequencer: loads the key into every encrypter, dispatches
// blocks strictly round-robin, and grants Collector captures in dispatch
// order using an order FIFO of encrypter indices. Key reload waits until
// every in-flight block has been captured.
module encrypter_dispatch_scheduler #(
    parameter int unsigned NUM_ENC     = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ROT_W       = 5,
    parameter int unsigned ORDER_DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    encrypter_dispatch_scheduler_if.master bus
);
    localparam int unsigned SEL_W = $clog2(NUM_ENC);
    localparam int unsigned PTR_W = $clog2(ORDER_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StProg, StRun, StDrain} state_e;

    state_e              r_state;
    logic [SEL_W-1:0]    r_rr;
    logic [ROT_W-1:0]    r_rot;
    logic [SEL_W-1:0]    r_fifo [ORDER_DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_enc_data;
    logic [ROT_W-1:0]    r_enc_rot;
    logic [NUM_ENC-1:0]  r_enc_program;
    logic [NUM_ENC-1:0]  r_enc_data_ready;
    logic                r_key_loaded;

    logic                w_empty;
    logic                w_full;
    logic [SEL_W-1:0]    w_head;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_push;
    logic                w_col_valid;
    logic                w_pop;
    logic [NUM_ENC-1:0]  w_capture;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(ORDER_DEPTH));
    assign w_head      = r_fifo[r_rptr];
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_push      = w_accept & (r_state == StRun);
    // Only the head-of-order encrypter may retire; other done flags wait.
    assign w_col_valid = ~w_empty & bus.enc_done[w_head];
    assign w_pop       = w_col_valid & bus.col_ready;

    // Input acceptance: always in PROG; in RUN only when the rr target is idle
    // and there is order-FIFO room (registered full, so a same-cycle pop does
    // not open a slot) and no reload is pending.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            StProg:  w_in_ready = 1'b1;
            StRun:   w_in_ready = bus.enc_ready[r_rr] & ~w_full & ~bus.prog_start;
            default: w_in_ready = 1'b0;
        endcase
    end

    // Capture grant to the head-of-order encrypter.
    always_comb begin
        w_capture = '0;
        if (w_pop) begin
            w_capture[w_head] = 1'b1;
        end
    end

    // Control FSM with registered broadcast data and one-cycle strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= StIdle;
            r_rr             <= '0;
            r_rot            <= '0;
            r_enc_data       <= '0;
            r_enc_rot        <= '0;
            r_enc_program    <= '0;
            r_enc_data_ready <= '0;
            r_key_loaded     <= 1'b0;
        end else begin
            r_enc_program    <= '0;
            r_enc_data_ready <= '0;
            case (r_state)
                StIdle: begin
                    if (bus.prog_start) begin
                        r_state <= StProg;
                    end
                end
                StProg: begin
                    if (w_accept) begin
                        r_enc_data    <= bus.in_data;
                        r_enc_program <= '1;
                        r_rot         <= '0;
                        r_rr          <= '0;
                        r_key_loaded  <= 1'b1;
                        r_state       <= StRun;
                    end
                end
                StRun: begin
                    if (bus.prog_start) begin
                        r_state <= w_empty ? StProg : StDrain;
                    end else if (w_accept) begin
                        r_enc_data       <= bus.in_data;
                        r_enc_data_ready <= {{(NUM_ENC-1){1'b0}}, 1'b1} << r_rr;
                        r_enc_rot        <= r_rot;
                        r_rr             <= r_rr + 1'b1;
                        r_rot            <= r_rot + 1'b1;
                    end
                end
                StDrain: begin
                    if (w_empty) begin
                        r_state <= StProg;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Order FIFO of dispatched encrypter indices plus the in-flight count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ORDER_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= r_rr;
                r_wptr         <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready         = w_in_ready;
    assign bus.enc_data         = r_enc_data;
    assign bus.enc_key_rotation = r_enc_rot;
    assign bus.enc_program      = r_enc_program;
    assign bus.enc_data_ready   = r_enc_data_ready;
    assign bus.enc_capture      = w_capture;
    assign bus.col_valid        = w_col_valid;
    assign bus.col_sel          = w_head;
    assign bus.key_loaded       = r_key_loaded;
    assign bus.inflight         = r_count;
endmodule

// File: tb/tb_encrypter_dispatch_scheduler.sv
// Randomized bench for the dispatch scheduler. A queue-based reference model
// predicts acceptance, dispatch strobes and capture order; a separate monitor
// consumes the expected strobes from scoreboard queues.
module tb_encrypter_dispatch_scheduler;
    localparam int NUM_ENC = 4;
    localparam int DATA_W  = 32;
    localparam int ROT_W   = 5;
    localparam int DEPTH   = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    encrypter_dispatch_scheduler_if #(
        .NUM_ENC(NUM_ENC), .DATA_W(DATA_W), .ROT_W(ROT_W), .ORDER_DEPTH(DEPTH)
    ) bus ();

    encrypter_dispatch_scheduler #(
        .NUM_ENC(NUM_ENC), .DATA_W(DATA_W), .ROT_W(ROT_W), .ORDER_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard entries
    typedef struct {
        bit              prog;
        int              idx;
        logic [31:0]     data;
        int              rot;
    } disp_t;

    disp_t stage_q[$];   // predicted this cycle, visible after next edge
    disp_t disp_q[$];    // due at the coming negedge
    int    cap_q[$];     // captures due at the coming negedge

    // Reference model: mode 0 idle, 1 key load, 2 run, 3 drain
    int ord_q[$];
    int mode  = 0;
    int m_rr  = 0;
    int m_rot = 0;
    bit m_key = 1'b0;

    // Stimulus control
    bit                 use_dir = 1'b1;
    bit                 dir_prog, dir_valid, dir_col;
    logic [31:0]        dir_data;
    logic [NUM_ENC-1:0] dir_rdy, dir_done;
    int p_valid, p_rdy, p_done, p_col, p_prog;

    task automatic zero_inputs();
        bus.prog_start = 1'b0;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.enc_ready  = '0;
        bus.enc_done   = '0;
        bus.col_ready  = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_enc_data", bus.enc_data, 0);
        chk("rst_rotation", bus.enc_key_rotation, 0);
        chk("rst_program", bus.enc_program, 0);
        chk("rst_data_ready", bus.enc_data_ready, 0);
        chk("rst_capture", bus.enc_capture, 0);
        chk("rst_col_valid", bus.col_valid, 0);
        chk("rst_col_sel", bus.col_sel, 0);
        chk("rst_key_loaded", bus.key_loaded, 0);
        chk("rst_inflight", bus.inflight, 0);
    endtask

    // One clock of stimulus plus model prediction and combinational checks.
    task automatic cycle();
        bit exp_rdy, exp_cv, hs, cap;
        int n;
        @(posedge clk);
        #1;
        while (stage_q.size() > 0) disp_q.push_back(stage_q.pop_front());
        if (use_dir) begin
            bus.prog_start = dir_prog;
            bus.in_valid   = dir_valid;
            bus.in_data    = dir_data;
            bus.enc_ready  = dir_rdy;
            bus.enc_done   = dir_done;
            bus.col_ready  = dir_col;
        end else begin
            bus.prog_start = ($urandom_range(99) < p_prog);
            bus.in_valid   = ($urandom_range(99) < p_valid);
            bus.in_data    = $urandom;
            for (int i = 0; i < NUM_ENC; i++) begin
                bus.enc_ready[i] = ($urandom_range(99) < p_rdy);
                bus.enc_done[i]  = ($urandom_range(99) < p_done);
            end
            bus.col_ready = ($urandom_range(99) < p_col);
        end
        #1;
        n       = ord_q.size();
        exp_rdy = (mode == 1) ||
                  (mode == 2 && bus.enc_ready[m_rr] && n < DEPTH && !bus.prog_start);
        exp_cv  = (n > 0) && bus.enc_done[ord_q[0]];
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("col_valid", bus.col_valid, exp_cv);
        chk("inflight", bus.inflight, n);
        chk("key_loaded", bus.key_loaded, m_key);
        if (n > 0) chk("col_sel", bus.col_sel, ord_q[0]);
        hs  = bus.in_valid && exp_rdy;
        cap = exp_cv && bus.col_ready;
        if (cap) cap_q.push_back(ord_q.pop_front());
        case (mode)
            0: if (bus.prog_start) mode = 1;
            1: if (hs) begin
                stage_q.push_back('{prog: 1'b1, idx: 0, data: bus.in_data, rot: 0});
                m_key = 1'b1;
                m_rr  = 0;
                m_rot = 0;
                mode  = 2;
            end
            2: if (bus.prog_start) begin
                mode = (n == 0) ? 1 : 3;
            end else if (hs) begin
                stage_q.push_back('{prog: 1'b0, idx: m_rr, data: bus.in_data, rot: m_rot});
                ord_q.push_back(m_rr);
                m_rr  = (m_rr + 1) % NUM_ENC;
                m_rot = (m_rot + 1) % (1 << ROT_W);
            end
            3: if (n == 0) mode = 1;
            default: mode = 0;
        endcase
    endtask

    task automatic dir(input bit prog, input bit valid, input logic [31:0] data,
                       input logic [NUM_ENC-1:0] rdy, input logic [NUM_ENC-1:0] done,
                       input bit col);
        dir_prog  = prog;
        dir_valid = valid;
        dir_data  = data;
        dir_rdy   = rdy;
        dir_done  = done;
        dir_col   = col;
        cycle();
    endtask

    // Retire everything in flight, bounded.
    task automatic drain_all();
        for (int i = 0; i < 20 && ord_q.size() > 0; i++) begin
            dir(1'b0, 1'b0, 32'h0, '1, '1, 1'b1);
        end
        chk("drain_bound", ord_q.size(), 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        zero_inputs();
        reset = 1'b0;
        #1;
        check_reset_vals();
        stage_q.delete();
        disp_q.delete();
        cap_q.delete();
        ord_q.delete();
        mode  = 0;
        m_rr  = 0;
        m_rot = 0;
        m_key = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: consume expected strobes whenever the DUT presents one.
    initial begin
        disp_t e;
        logic [NUM_ENC-1:0] oh;
        int c;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus.enc_program != '0 || bus.enc_data_ready != '0) begin
                    if (disp_q.size() == 0) begin
                        chk("unexpected_strobe", {bus.enc_program, bus.enc_data_ready}, 0);
                    end else begin
                        e  = disp_q.pop_front();
                        oh = '0;
                        if (!e.prog) oh[e.idx] = 1'b1;
                        chk("enc_program", bus.enc_program, e.prog ? {NUM_ENC{1'b1}} : '0);
                        chk("enc_data_ready", bus.enc_data_ready, oh);
                        chk("enc_data", bus.enc_data, e.data);
                        if (!e.prog) chk("enc_key_rotation", bus.enc_key_rotation, e.rot);
                    end
                end
                if (bus.enc_capture != '0) begin
                    if (cap_q.size() == 0) begin
                        chk("unexpected_capture", bus.enc_capture, 0);
                    end else begin
                        c  = cap_q.pop_front();
                        oh = '0;
                        oh[c] = 1'b1;
                        chk("enc_capture", bus.enc_capture, oh);
                    end
                end
                chk("missed_strobe", disp_q.size(), 0);
                chk("missed_capture", cap_q.size(), 0);
                disp_q.delete();
                cap_q.delete();
            end
        end
    end

    initial begin
        zero_inputs();
        #12;
        check_reset_vals();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Key load
        dir(1'b1, 1'b0, 32'h0, '0, '0, 1'b0);
        dir(1'b0, 1'b1, 32'hB4352B93, '0, '0, 1'b0);
        dir(1'b0, 1'b0, 32'h0, '0, '0, 1'b0);

        // Six back-to-back blocks, round-robin, rotations 0..5
        for (int i = 0; i < 6; i++) dir(1'b0, 1'b1, 32'h1000 + i, '1, '0, 1'b0);
        dir(1'b0, 1'b0, 32'h0, '1, '0, 1'b0);
        drain_all();

        // Ordered retire: rr is back at a known slot; dispatch one per encrypter
        for (int i = 0; i < NUM_ENC; i++) dir(1'b0, 1'b1, 32'h2000 + i, '1, '0, 1'b0);
        begin
            logic [NUM_ENC-1:0] seq [7];
            int h;
            seq[0] = 4'b1000; seq[1] = 4'b1010; seq[2] = 4'b1011; seq[3] = 4'b1011;
            seq[4] = 4'b1011; seq[5] = 4'b1111; seq[6] = 4'b1111;
            // Rotate pattern so it is relative to the first dispatched encrypter
            h = ord_q[0];
            for (int i = 0; i < 7; i++) begin
                logic [NUM_ENC-1:0] rs;
                rs = '0;
                for (int b = 0; b < NUM_ENC; b++) rs[(b + h) % NUM_ENC] = seq[i][b];
                dir(1'b0, 1'b0, 32'h0, '1, rs, 1'b1);
            end
        end
        drain_all();

        // Fill the order FIFO, then free one slot
        for (int i = 0; i < 10; i++) dir(1'b0, 1'b1, 32'h3000 + i, '1, '0, 1'b0);
        dir(1'b0, 1'b1, 32'h3100, '1, '1, 1'b1);
        dir(1'b0, 1'b1, 32'h3101, '1, '0, 1'b0);
        dir(1'b0, 1'b0, 32'h0, '1, '0, 1'b0);
        drain_all();

        // Stall on a busy encrypter at the rr slot
        for (int i = 0; i < 3; i++) begin
            logic [NUM_ENC-1:0] busy;
            busy = '1;
            busy[m_rr] = 1'b0;
            dir(1'b0, 1'b1, 32'h4000 + i, busy, '0, 1'b0);
        end
        dir(1'b0, 1'b1, 32'h4010, '1, '0, 1'b0);
        drain_all();

        // Reprogram with three blocks in flight
        for (int i = 0; i < 3; i++) dir(1'b0, 1'b1, 32'h5000 + i, '1, '0, 1'b0);
        dir(1'b1, 1'b1, 32'h5100, '1, '0, 1'b0);
        dir(1'b1, 1'b1, 32'h5101, '1, '0, 1'b0);
        chk("drain_mode", mode, 3);
        for (int i = 0; i < 4; i++) dir(1'b1, 1'b1, 32'h5200 + i, '1, '1, 1'b1);
        dir(1'b0, 1'b1, 32'hC0FFEE01, '1, '0, 1'b0);
        dir(1'b0, 1'b0, 32'h0, '1, '0, 1'b0);
        chk("reload_key", m_key, 1);

        // Randomized phases, with one mid-operation reset
        use_dir = 1'b0;
        for (int ph = 0; ph < 10; ph++) begin
            p_valid = $urandom_range(30, 100);
            p_rdy   = $urandom_range(40, 100);
            p_done  = $urandom_range(10, 90);
            p_col   = $urandom_range(20, 100);
            p_prog  = (ph % 3 == 2) ? 4 : 1;
            if (ph == 5) mid_reset();
            for (int i = 0; i < 200; i++) cycle();
        end
        use_dir = 1'b1;
        drain_all();
        dir(1'b0, 1'b0, 32'h0, '0, '0, 1'b0);
        @(negedge clk);
        #1;
        chk("final_stage_empty", stage_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
